// File: rtl/imem_loader_if.sv
// imem_loader_if: load control, byte-stream handshake and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int memory_width   = 32,
    parameter int memory_address = 8
);
    logic                      start;
    logic [memory_address:0]   word_count;
    logic                      in_valid;
    logic [7:0]                in_byte;
    logic                      in_ready;
    logic                      WE;
    logic [memory_address-1:0] WA;
    logic [memory_width-1:0]   WD;
    logic                      busy;
    logic                      done;
    logic                      cpu_rst_n;

    modport master (
        output start, word_count, in_valid, in_byte,
        input  in_ready, WE, WA, WD, busy, done, cpu_rst_n
    );

    modport slave (
        input  start, word_count, in_valid, in_byte,
        output in_ready, WE, WA, WD, busy, done, cpu_rst_n
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words, writes them to instruction memory,
// zero-fills the remainder and holds the core in reset until the load completes.
module imem_loader #(
    parameter int memory_width   = 32,
    parameter int memory_address = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam logic [memory_address:0]   full     = {1'b1, {memory_address{1'b0}}};
    localparam logic [memory_address:0]   one_w    = (memory_address+1)'(1);
    localparam logic [memory_address-1:0] one_a    = memory_address'(1);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, DONE} state_t;

    state_t                    state_q, state_d;
    logic [memory_width-1:0]   word_q, word_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [memory_address-1:0] addr_q, addr_d;
    logic [memory_address:0]   rem_q, rem_d;
    logic [memory_address:0]   count_clip;
    logic                      cpu_rst_n_q;

    assign count_clip = (bus.word_count > full) ? full : bus.word_count;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (bus.start) begin
                rem_d   = count_clip;
                addr_d  = '0;
                cnt_d   = '0;
                state_d = (count_clip != '0) ? RECV : FILL;
            end
            RECV: if (bus.in_valid) begin
                word_d  = {word_q[memory_width-9:0], bus.in_byte};
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd3) ? WRITE : RECV;
            end
            WRITE: begin
                addr_d  = addr_q + one_a;
                rem_d   = rem_q - one_w;
                // a full-depth program wraps the address to 0 and leaves nothing to fill
                state_d = (rem_q != one_w) ? RECV : ((addr_d == '0) ? DONE : FILL);
            end
            FILL: begin
                addr_d  = addr_q + one_a;
                state_d = (&addr_q) ? DONE : FILL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cpu_rst_n_q <= (state_d == IDLE);
        end
    end

    assign bus.in_ready  = (state_q == RECV);
    assign bus.WE        = (state_q == WRITE) || (state_q == FILL);
    assign bus.WA        = bus.WE ? addr_q : '0;
    assign bus.WD        = (state_q == WRITE) ? word_q : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.cpu_rst_n = cpu_rst_n_q;
endmodule
